top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_top.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// 82C43-style port expander bridged to an 8N1 UART.
// Ports P4..P7 sit at addresses 0..3 of the MCU port-2 bus. P4/P5 read the
// RX FIFO head (or the TX latch), P6 reads status and P7 holds the control
// register.
// Optional feature: define UART_CTS_FLOW_EN to make the transmitter wait
// for cts=0 before it sends the start bit.
`timescale 1ns/1ps

module top #(
  parameter int CLK_HZ   = 8000000,
  parameter int BAUD     = 125000,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_n,
  inout  wire  [3:0] p2,
  output logic [3:0] p2o,
  output logic       p2_buf_oe,
  input  logic       rx,
  output logic       tx,
  output logic       rts,
  input  logic       cts,
  output logic       LED
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int NW  = $clog2(RX_DEPTH + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(RX_DEPTH - 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(RX_DEPTH);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_OR    = 2'b10;
  localparam logic [1:0] OP_AND   = 2'b11;

  localparam logic [1:0] ADDR_P4 = 2'd0;
  localparam logic [1:0] ADDR_P5 = 2'd1;
  localparam logic [1:0] ADDR_P6 = 2'd2;
  localparam logic [1:0] ADDR_P7 = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_WAIT  = 3'd1;
  localparam logic [2:0] TX_START = 3'd2;
  localparam logic [2:0] TX_DATA  = 3'd3;
  localparam logic [2:0] TX_STOP  = 3'd4;

  // Apply a WRITE/OR/AND opcode to a 4-bit register.
  function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] cur,
                                       input logic [3:0] wd);
    logic [3:0] res;
    case (op)
      OP_WRITE: res = wd;
      OP_OR:    res = cur | wd;
      OP_AND:   res = cur & wd;
      default:  res = cur;
    endcase
    return res;
  endfunction

  // Advance a FIFO pointer with wrap at the last slot.
  function automatic logic [AW-1:0] ptr_inc_f(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  logic [3:0]    cmd_q, wdata_q;
  logic [2:0]    prog_sync_q;
  logic [2:0]    rx_sync_q;
  logic          fall_s, rise_s, wr_s, rd_p6_s;
  logic [1:0]    op_s, addr_s;
  logic          oe_q, oe_d, armed_q, armed_d;
  logic [3:0]    p2o_q, p2o_d, rdata_s, status_s;
  logic [3:0]    tx_lo_q, tx_lo_d, tx_hi_q, tx_hi_d, ctrl_q, ctrl_d;
  logic [2:1]    ctrl_prev_q;
  logic          pop_req_s, pop_s, load_s, push_ok_s, ovr_set_s;
  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d, empty_s, full_s;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_push_q, rx_push_d, rx_fall_s;
  logic [2:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d, tx_busy_s, cts_ok_s;

`ifdef UART_CTS_FLOW_EN
  logic [1:0] cts_sync_q;

  // Synchronise the host's clear-to-send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_sync_q <= 2'b11;
    else     cts_sync_q <= {cts_sync_q[0], cts};
  end
  assign cts_ok_s = ~cts_sync_q[1];
`else
  logic cts_unused_s;
  assign cts_unused_s = cts;
  assign cts_ok_s     = 1'b1;
`endif

  // Command latch: the MCU presents {op,addr} at the PROG falling edge.
  always_ff @(negedge prog_n or posedge rst) begin
    if (rst) cmd_q <= 4'b0000;
    else     cmd_q <= p2;
  end

  // Data latch: write data is valid at the PROG rising edge.
  always_ff @(posedge prog_n or posedge rst) begin
    if (rst) wdata_q <= 4'b0000;
    else     wdata_q <= p2;
  end

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_sync_q <= 3'b111;
      rx_sync_q   <= 3'b111;
    end else begin
      prog_sync_q <= {prog_sync_q[1:0], prog_n};
      rx_sync_q   <= {rx_sync_q[1:0], rx};
    end
  end

  assign fall_s    = prog_sync_q[2] & ~prog_sync_q[1];
  assign rise_s    = ~prog_sync_q[2] & prog_sync_q[1];
  assign op_s      = cmd_q[3:2];
  assign addr_s    = cmd_q[1:0];
  assign wr_s      = rise_s & armed_q & (op_s != OP_READ);
  assign rd_p6_s   = fall_s & (op_s == OP_READ) & (addr_s == ADDR_P6);
  assign rx_fall_s = rx_sync_q[2] & ~rx_sync_q[1];

  assign empty_s   = (count_q == {NW{1'b0}});
  assign full_s    = (count_q == CNT_FULL);
  assign tx_busy_s = (tx_state_q != TX_IDLE);
  assign status_s  = {tx_busy_s, full_s, ovr_q, empty_s | ~ctrl_q[1]};

  // Read mux for the addressed port.
  always_comb begin
    case (addr_s)
      ADDR_P4: rdata_s = ctrl_q[0] ? tx_lo_q : fifo_mem[rd_ptr_q][3:0];
      ADDR_P5: rdata_s = ctrl_q[0] ? tx_hi_q : fifo_mem[rd_ptr_q][7:4];
      ADDR_P6: rdata_s = status_s;
      default: rdata_s = ctrl_q;
    endcase
  end

  // Bus handshake: capture read data and arm the cycle on the synced fall.
  always_comb begin
    oe_d    = oe_q;
    p2o_d   = p2o_q;
    armed_d = armed_q;
    if (fall_s) begin
      armed_d = 1'b1;
      if (op_s == OP_READ) begin
        oe_d  = 1'b1;
        p2o_d = rdata_s;
      end else begin
        oe_d  = 1'b0;
      end
    end else if (rise_s) begin
      armed_d = 1'b0;
      oe_d    = 1'b0;
    end else begin
      armed_d = armed_q;
    end
  end

  // Port register updates on the synced rising edge; P6 writes fall through.
  always_comb begin
    tx_lo_d = tx_lo_q;
    tx_hi_d = tx_hi_q;
    ctrl_d  = ctrl_q;
    if (wr_s) begin
      case (addr_s)
        ADDR_P4: tx_lo_d = alu_f(op_s, tx_lo_q, wdata_q);
        ADDR_P5: tx_hi_d = alu_f(op_s, tx_hi_q, wdata_q);
        ADDR_P7: ctrl_d  = alu_f(op_s, ctrl_q, wdata_q);
        default: ctrl_d  = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Bus and port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q        <= 1'b0;
      armed_q     <= 1'b0;
      p2o_q       <= 4'b0000;
      tx_lo_q     <= 4'b0000;
      tx_hi_q     <= 4'b0000;
      ctrl_q      <= 4'b1111;
      ctrl_prev_q <= 2'b11;
    end else begin
      oe_q        <= oe_d;
      armed_q     <= armed_d;
      p2o_q       <= p2o_d;
      tx_lo_q     <= tx_lo_d;
      tx_hi_q     <= tx_hi_d;
      ctrl_q      <= ctrl_d;
      ctrl_prev_q <= ctrl_q[2:1];
    end
  end

  // The bus drops as soon as PROG rises, without waiting for the synchroniser.
  assign p2_buf_oe = oe_q & ~prog_n;
  assign p2        = p2_buf_oe ? p2o_q : 4'bzzzz;
  assign p2o       = p2o_q;
  assign LED       = ctrl_q[3];
  assign tx        = tx_q;
  assign rts       = full_s;

  // Control-bit falling transitions trigger a FIFO pop and a TX load.
  assign pop_req_s = ctrl_prev_q[1] & ~ctrl_q[1];
  assign load_s    = ctrl_prev_q[2] & ~ctrl_q[2] & ~tx_busy_s;
  assign pop_s     = pop_req_s & ~empty_s;
  assign push_ok_s = rx_push_q & (~full_s | pop_s);
  assign ovr_set_s = rx_push_q & full_s & ~pop_s;
  assign wr_ptr_d  = push_ok_s ? ptr_inc_f(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d  = pop_s ? ptr_inc_f(rd_ptr_q) : rd_ptr_q;

  // FIFO occupancy and overrun flag; a set wins over a P6 read clear.
  always_comb begin
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    if (ovr_set_s)    ovr_d = 1'b1;
    else if (rd_p6_s) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
  end

  // FIFO pointers, count and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {NW{1'b0}};
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) fifo_mem[wr_ptr_q] <= rx_shift_q;
  end

  // UART receiver: start check at mid-bit, then one sample per bit time.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = {CW{1'b0}};
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = {CW{1'b0}};
          rx_bit_d = 3'd0;
          if (!rx_sync_q[1]) rx_state_d = RX_DATA;
          else               rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = {CW{1'b0}};
          rx_shift_d = {rx_sync_q[1], rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = {CW{1'b0}};
          rx_state_d = RX_IDLE;
          rx_push_d  = rx_sync_q[1];
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // UART receiver registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= {CW{1'b0}};
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_push_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_push_q  <= rx_push_d;
    end
  end

  // UART transmitter: optional CTS wait, then start, 8 data LSB first, stop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (load_s) begin
          tx_shift_d = {tx_hi_q, tx_lo_q};
          tx_cnt_d   = {CW{1'b0}};
          if (cts_ok_s) begin
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_WAIT;
            tx_d       = 1'b1;
          end
        end else begin
          tx_d = 1'b1;
        end
      end
      TX_WAIT: begin
        if (cts_ok_s) begin
          tx_state_d = TX_START;
          tx_cnt_d   = {CW{1'b0}};
          tx_d       = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = {CW{1'b0}};
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = {CW{1'b0}};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = {CW{1'b0}};
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // UART transmitter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= {CW{1'b0}};
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: MCU PROG cycles, UART host sender and a
// scoreboard queue of expected bytes.
`timescale 1ns/1ps

module tb_top;

  logic       clk = 1'b0;
  logic       rst, prog_n, rx, cts;
  logic       tb_oe;
  logic [3:0] tb_p2;
  wire  [3:0] p2;
  logic [3:0] p2o;
  logic       p2_buf_oe, tx, rts, LED;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] sb_q[$];

  assign p2 = tb_oe ? tb_p2 : 4'bzzzz;

  top dut (
    .clk(clk), .rst(rst), .prog_n(prog_n), .p2(p2), .p2o(p2o),
    .p2_buf_oe(p2_buf_oe), .rx(rx), .tx(tx), .rts(rts), .cts(cts), .LED(LED)
  );

  always #62.5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; prog_n = 1'b1; rx = 1'b1; cts = 1'b0; tb_oe = 1'b0; tb_p2 = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One PROG cycle: 50 ns command setup, 60 ns hold, 700 ns low.
  task automatic mcu(input logic [1:0] op, input logic [1:0] addr,
                     input logic [3:0] wd, output logic [3:0] rd);
    @(negedge clk); #10;
    tb_oe = 1'b1; tb_p2 = {op, addr};
    #50 prog_n = 1'b0;
    #60;
    if (op == 2'b00) tb_oe = 1'b0;
    else             tb_p2 = wd;
    #630 rd = p2;
    #10 prog_n = 1'b1;
    #20 tb_oe = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk); rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (64) @(negedge clk);
    end
    rx = stop_bit;
    repeat (64) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] rd;
    rst = 1'b1; prog_n = 1'b1; rx = 1'b1; cts = 1'b0; tb_oe = 1'b0; tb_p2 = 4'b0000;
    repeat (2) @(negedge clk);
    tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx got %b want 1", tx); end
    tests_run++; if (p2_buf_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe got %b want 0", p2_buf_oe); end
    tests_run++; if (p2o !== 4'b0000) begin tests_failed++; $display("FAIL reset_p2o got %b want 0000", p2o); end
    tests_run++; if (LED !== 1'b1) begin tests_failed++; $display("FAIL reset_led got %b want 1", LED); end
    tests_run++; if (rts !== 1'b0) begin tests_failed++; $display("FAIL reset_rts got %b want 0", rts); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mcu(2'b00, 2'd2, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0001) begin tests_failed++; $display("FAIL reset_p6 got %b want 0001", rd); end
    mcu(2'b00, 2'd3, 4'b0000, rd);
    tests_run++; if (rd !== 4'b1111) begin tests_failed++; $display("FAIL reset_p7 got %b want 1111", rd); end
  endtask

  task automatic test_prog_timing();
    do_reset();
    @(negedge clk); #10;
    tb_oe = 1'b1; tb_p2 = 4'b0011;
    #50 prog_n = 1'b0;
    #59;
    tests_run++; if (p2_buf_oe !== 1'b0) begin tests_failed++; $display("FAIL prog_early_drive got %b want 0", p2_buf_oe); end
    #1 tb_oe = 1'b0;
    #630;
    tests_run++; if (p2_buf_oe !== 1'b1) begin tests_failed++; $display("FAIL prog_oe_700 got %b want 1", p2_buf_oe); end
    tests_run++; if (p2 !== 4'b1111) begin tests_failed++; $display("FAIL prog_data_700 got %b want 1111", p2); end
    #10 prog_n = 1'b1;
    #1;
    tests_run++; if (p2_buf_oe !== 1'b0) begin tests_failed++; $display("FAIL prog_release got %b want 0", p2_buf_oe); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_rx_readback();
    logic [7:0] bytes [4];
    logic [3:0] rd, lo, hi;
    logic [7:0] exp;
    bit ok;
    bytes[0] = 8'hDE; bytes[1] = 8'hAD; bytes[2] = 8'hBE; bytes[3] = 8'hEF;
    do_reset();
    sb_q.delete();
    fork
      begin
        for (int n = 0; n < 4; n++) begin
          for (int k = 0; k < 5000 && rts; k++) @(negedge clk);
          tests_run++; if (rts !== 1'b0) begin tests_failed++; $display("FAIL rb_rts_wait got %b want 0", rts); end
          sb_q.push_back(bytes[n]);
          send_byte(bytes[n], 1'b1);
        end
      end
      begin
        mcu(2'b01, 2'd3, 4'b1111, rd);
        mcu(2'b01, 2'd3, 4'b1110, rd);
        for (int n = 0; n < 4; n++) begin
          ok = 1'b0;
          for (int k = 0; k < 150 && !ok; k++) begin
            mcu(2'b00, 2'd2, 4'b0000, rd);
            if (rd[0] == 1'b0) ok = 1'b1;
          end
          tests_run++; if (!ok) begin tests_failed++; $display("FAIL rb_poll_data got timeout want P6[0]=0"); end
          mcu(2'b00, 2'd0, 4'b0000, lo);
          mcu(2'b00, 2'd1, 4'b0000, hi);
          exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
          tests_run++; if ({hi, lo} !== exp) begin tests_failed++; $display("FAIL rb_byte%0d got %h want %h", n, {hi, lo}, exp); end
          mcu(2'b11, 2'd3, 4'b1101, rd);
          ok = 1'b0;
          for (int k = 0; k < 10 && !ok; k++) begin
            mcu(2'b00, 2'd2, 4'b0000, rd);
            if (rd[0] == 1'b1) ok = 1'b1;
          end
          tests_run++; if (!ok) begin tests_failed++; $display("FAIL rb_poll_empty got timeout want P6[0]=1"); end
          mcu(2'b10, 2'd3, 4'b1110, rd);
        end
      end
    join
  endtask

  task automatic test_overrun();
    logic [7:0] bytes [5];
    logic [3:0] rd, lo, hi;
    logic [7:0] exp;
    bytes[0] = 8'h31; bytes[1] = 8'h52; bytes[2] = 8'hA7; bytes[3] = 8'h0F; bytes[4] = 8'hC3;
    do_reset();
    sb_q.delete();
    for (int n = 0; n < 5; n++) begin
      if (n < 4) sb_q.push_back(bytes[n]);
      send_byte(bytes[n], 1'b1);
      repeat (4) @(negedge clk);
      if (n == 2) begin
        tests_run++; if (rts !== 1'b0) begin tests_failed++; $display("FAIL ovr_rts3 got %b want 0", rts); end
      end
      if (n == 3) begin
        tests_run++; if (rts !== 1'b1) begin tests_failed++; $display("FAIL ovr_rts4 got %b want 1", rts); end
      end
    end
    mcu(2'b00, 2'd2, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0110) begin tests_failed++; $display("FAIL ovr_p6_set got %b want 0110", rd); end
    mcu(2'b00, 2'd2, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0100) begin tests_failed++; $display("FAIL ovr_p6_clr got %b want 0100", rd); end
    mcu(2'b01, 2'd3, 4'b1110, rd);
    for (int n = 0; n < 4; n++) begin
      mcu(2'b00, 2'd0, 4'b0000, lo);
      mcu(2'b00, 2'd1, 4'b0000, hi);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
      tests_run++; if ({hi, lo} !== exp) begin tests_failed++; $display("FAIL ovr_drain%0d got %h want %h", n, {hi, lo}, exp); end
      mcu(2'b11, 2'd3, 4'b1101, rd);
      mcu(2'b10, 2'd3, 4'b1110, rd);
    end
    mcu(2'b00, 2'd2, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0001) begin tests_failed++; $display("FAIL ovr_final_p6 got %b want 0001", rd); end
    tests_run++; if (rts !== 1'b0) begin tests_failed++; $display("FAIL ovr_final_rts got %b want 0", rts); end
  endtask

  task automatic test_rx_errors();
    logic [3:0] rd, lo, hi;
    do_reset();
    @(negedge clk); rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    send_byte(8'h5A, 1'b0);
    repeat (100) @(negedge clk);
    mcu(2'b00, 2'd2, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0001) begin tests_failed++; $display("FAIL err_dropped got %b want 0001", rd); end
    send_byte(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    mcu(2'b00, 2'd2, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0000) begin tests_failed++; $display("FAIL err_good_p6 got %b want 0000", rd); end
    mcu(2'b01, 2'd3, 4'b1110, rd);
    mcu(2'b00, 2'd0, 4'b0000, lo);
    mcu(2'b00, 2'd1, 4'b0000, hi);
    tests_run++; if ({hi, lo} !== 8'h3C) begin tests_failed++; $display("FAIL err_good_byte got %h want 3c", {hi, lo}); end
  endtask

  task automatic test_tx();
    logic [3:0] rd_a, rd;
    logic [7:0] got, exp;
    bit seen;
    do_reset();
    sb_q.delete();
    mcu(2'b01, 2'd0, 4'b0100, rd);
    mcu(2'b01, 2'd1, 4'b0100, rd);
    sb_q.push_back(8'h44);
    fork
      begin
        mcu(2'b11, 2'd3, 4'b1011, rd_a);
        mcu(2'b00, 2'd2, 4'b0000, rd_a);
        tests_run++; if (rd_a[3] !== 1'b1) begin tests_failed++; $display("FAIL tx_busy_during got %b want 1", rd_a[3]); end
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
          @(negedge clk);
          if (tx == 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
          tests_failed++; $display("FAIL tx_start got timeout want tx=0");
        end else begin
          repeat (32) @(negedge clk);
          tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL tx_start_mid got %b want 0", tx); end
          for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk);
            got[i] = tx;
          end
          repeat (64) @(negedge clk);
          tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL tx_stop got %b want 1", tx); end
          exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
          tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL tx_byte got %h want %h", got, exp); end
        end
      end
    join
    repeat (40) @(negedge clk);
    mcu(2'b00, 2'd2, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0001) begin tests_failed++; $display("FAIL tx_busy_after got %b want 0001", rd); end
  endtask

  task automatic test_tx_latch();
    logic [3:0] rd;
    do_reset();
    mcu(2'b01, 2'd0, 4'b1001, rd);
    mcu(2'b10, 2'd0, 4'b0110, rd);
    mcu(2'b11, 2'd0, 4'b0101, rd);
    mcu(2'b01, 2'd1, 4'b1010, rd);
    mcu(2'b00, 2'd0, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0101) begin tests_failed++; $display("FAIL latch_p4 got %b want 0101", rd); end
    mcu(2'b00, 2'd1, 4'b0000, rd);
    tests_run++; if (rd !== 4'b1010) begin tests_failed++; $display("FAIL latch_p5 got %b want 1010", rd); end
    mcu(2'b01, 2'd2, 4'b1111, rd);
    mcu(2'b00, 2'd2, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0001) begin tests_failed++; $display("FAIL latch_p6_wr got %b want 0001", rd); end
    mcu(2'b01, 2'd3, 4'b0110, rd);
    mcu(2'b00, 2'd3, 4'b0000, rd);
    tests_run++; if (rd !== 4'b0110) begin tests_failed++; $display("FAIL latch_p7 got %b want 0110", rd); end
    tests_run++; if (LED !== 1'b0) begin tests_failed++; $display("FAIL latch_led got %b want 0", LED); end
  endtask

`ifdef UART_CTS_FLOW_EN
  task automatic test_cts();
    logic [3:0] rd;
    bit seen;
    do_reset();
    cts = 1'b1;
    mcu(2'b01, 2'd0, 4'b0100, rd);
    mcu(2'b11, 2'd3, 4'b1011, rd);
    repeat (200) @(negedge clk);
    tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL cts_hold_tx got %b want 1", tx); end
    mcu(2'b00, 2'd2, 4'b0000, rd);
    tests_run++; if (rd[3] !== 1'b1) begin tests_failed++; $display("FAIL cts_hold_busy got %b want 1", rd[3]); end
    cts = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (tx == 1'b0) seen = 1'b1;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL cts_release got timeout want tx=0"); end
  endtask
`endif

  initial begin
    test_reset();
    test_prog_timing();
    test_rx_readback();
    test_overrun();
    test_rx_errors();
    test_tx();
    test_tx_latch();
`ifdef UART_CTS_FLOW_EN
    test_cts();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
